// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: watches a CPU fetch stream from the reset vector to the halt address
// and reports a sticky done/pass/fail verdict, with a cycle timeout and a misaligned-fetch trap.
module cpu_run_monitor #(
  parameter logic [31:0] RESET_VECTOR   = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDRESS   = 32'h00000000,
  parameter int          TIMEOUT_CYCLES = 200,
  parameter int          CYCLE_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_enable,
  input  logic               active,
  input  logic [31:0]        instr_address,
  input  logic [31:0]        register_v0,
  input  logic               check_enable,
  input  logic [31:0]        expected_v0,
  output logic [2:0]         state,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic               timeout,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic [31:0]        captured_v0
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_HALTED  = 3'd2;
  localparam logic [2:0] S_TIMEOUT = 3'd3;
  localparam logic [2:0] S_FAULT   = 3'd4;
  logic [2:0]         state_q, state_d;
  logic [CYCLE_W-1:0] cycle_count_q, cycle_count_d;
  logic [31:0]        captured_v0_q, captured_v0_d;
  logic               pass_q, pass_d, fail_q, fail_d;
  logic               halt, fault, expire, match;
  always_comb begin
    halt = !active || instr_address == HALT_ADDRESS;
    fault = |instr_address[1:0];
    expire = cycle_count_q == CYCLE_W'(TIMEOUT_CYCLES - 1);
    match = !check_enable || register_v0 == expected_v0;
    state_d = state_q;
    cycle_count_d = cycle_count_q;
    captured_v0_d = captured_v0_q;
    pass_d = pass_q;
    fail_d = fail_q;
    if (state_q == S_IDLE && active && instr_address == RESET_VECTOR) begin
      state_d = S_RUN;
      cycle_count_d = CYCLE_W'(1);
    end else if (state_q == S_RUN) begin
      // halt outranks fault, both outrank timeout; the exit edge leaves the count as it was
      if (halt || fault) begin
        state_d = halt ? S_HALTED : S_FAULT;
        captured_v0_d = register_v0;
        pass_d = halt && match;
        fail_d = !(halt && match);
      end else if (expire) begin
        state_d = S_TIMEOUT;
        fail_d = 1'b1;
      end else begin
        cycle_count_d = cycle_count_q + CYCLE_W'(!(&cycle_count_q));
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cycle_count_q <= '0;
      captured_v0_q <= '0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else if (clk_enable) begin
      state_q <= state_d;
      cycle_count_q <= cycle_count_d;
      captured_v0_q <= captured_v0_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
    end
  end
  assign state = state_q;
  assign pass = pass_q;
  assign fail = fail_q;
  assign done = pass_q | fail_q;
  assign timeout = state_q == S_TIMEOUT;
  assign cycle_count = cycle_count_q;
  assign captured_v0 = captured_v0_q;
endmodule
